// File: rtl/mask_pkg.sv
// -----------------------------------------------------------------------------
// mask_pkg
// Shared definitions for the mask_feeder block:
//   - default stream width, FIFO depth and frame length
//   - the frame-sequencer state encoding
//   - a pointer-width helper used by the FIFO
// No ports (package).
// -----------------------------------------------------------------------------
package mask_pkg;

  localparam int MASK_DATA_W    = 8;
  localparam int MASK_DEPTH     = 16;
  localparam int MASK_FRAME_LEN = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // Address width for a power-of-two FIFO; never below one bit so the
  // pointer declarations stay legal for tiny depths.
  function automatic int ptr_width(input int depth);
    int w;
    w = $clog2(depth);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a combinational head read. Occupancy is tracked in a
// 0..DEPTH counter from which full/empty are derived; read and write pointers
// wrap naturally modulo DEPTH (DEPTH must be a power of two, at least 2).
// A push is honoured while full only when a pop happens in the same cycle:
// the popped slot is the one the write lands in, and the head is read before
// the write takes effect, so the outgoing byte is never corrupted.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset, empties the FIFO
//   push   in   write request
//   pop    in   read request (ignored when empty)
//   din    in   write data
//   dout   out  current head entry (valid when !empty)
//   full   out  DEPTH entries held
//   empty  out  no entries held
// -----------------------------------------------------------------------------
module sync_fifo
  import mask_pkg::*;
#(
  parameter int DATA_W = MASK_DATA_W,
  parameter int DEPTH  = MASK_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int            AW      = ptr_width(DEPTH);
  localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_ONE   = (AW+1)'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;

  logic              w_pop;
  logic              w_push;

  assign full  = (r_count == C_DEPTH);
  assign empty = (r_count == '0);
  assign dout  = r_mem[r_rd_ptr];

  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  // Control: pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage: data is not reset; pointers define what is valid
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/mask_feeder.sv
// -----------------------------------------------------------------------------
// mask_feeder
// Buffers an upstream byte stream in a FIFO and releases exactly FRAME_LEN
// bytes per frame to a downstream consumer that can apply backpressure.
// A start pulse opens a frame; the frame closes on the edge carrying the
// final byte, after which done stays high until the next start or reset.
// Upstream writes are accepted in every state; a write arriving while the
// FIFO is full and nothing is leaving is dropped and latches overflow.
// Bytes still queued when a frame closes lead the next frame.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset (highest priority)
//   start       in   one-cycle frame start pulse (ignored while sending)
//   wr_en       in   upstream write strobe
//   wr_data     in   upstream byte
//   full        out  FIFO holds DEPTH bytes
//   overflow    out  sticky: a write was dropped
//   busy        in   downstream backpressure, no byte sent while high
//   data_out    out  registered byte to downstream
//   data_valid  out  data_out carries a new byte this cycle
//   done        out  frame complete, held until next start or reset
// -----------------------------------------------------------------------------
module mask_feeder
  import mask_pkg::*;
#(
  parameter int DATA_W    = MASK_DATA_W,
  parameter int DEPTH     = MASK_DEPTH,
  parameter int FRAME_LEN = MASK_FRAME_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              overflow,
  input  logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              done
);

  // One extra bit so a full frame of 2**DATA_W bytes is representable.
  localparam int            CW      = DATA_W + 1;
  localparam logic [CW-1:0] C_FRAME = CW'(FRAME_LEN);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_dout;
  logic              r_dv;
  logic              r_done;
  logic              r_ovf;

  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [CW-1:0]     w_cnt_nxt;

  // A byte leaves only while sending, downstream is ready, something is
  // queued, and the frame is not yet complete. Because the head comes from
  // registered storage, a byte written this edge cannot leave before the next.
  assign w_pop     = (r_state == SEND) && !busy && !w_empty && (r_cnt < C_FRAME);
  assign w_push    = wr_en && (!w_full || w_pop);
  assign w_drop    = wr_en && w_full && !w_pop;
  assign w_cnt_nxt = r_cnt + C_ONE;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (wr_data),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // Frame sequencer, byte counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_dv    <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_dv <= w_pop;
      if (w_pop)  r_dout <= w_head;
      if (w_drop) r_ovf  <= 1'b1;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= SEND;
            r_cnt   <= '0;
            r_done  <= 1'b0;
          end
        end
        SEND: begin
          // start is deliberately not looked at here
          if (w_pop) begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == C_FRAME) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (start) begin
            r_state <= SEND;
            r_cnt   <= '0;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign full       = w_full;
  assign overflow   = r_ovf;
  assign data_out   = r_dout;
  assign data_valid = r_dv;
  assign done       = r_done;

endmodule

// File: tb/tb_mask_feeder.sv
// -----------------------------------------------------------------------------
// tb_mask_feeder
// Scoreboard bench for mask_feeder. The driver applies inputs one cycle at a
// time and advances a queue-based reference model of the frame feeder; bytes
// the model expects to leave are pushed onto a scoreboard queue. A monitor on
// the falling edge checks every cycle's outputs against the model and pops
// the scoreboard whenever the DUT presents data_valid.
// -----------------------------------------------------------------------------
module tb_mask_feeder;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int FL    = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          overflow;
  logic          busy;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          done;

  mask_feeder #(
    .DATA_W    (DW),
    .DEPTH     (DEPTH),
    .FRAME_LEN (FL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .overflow   (overflow),
    .busy       (busy),
    .data_out   (data_out),
    .data_valid (data_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_obs = 0;

  // Reference model state
  logic [DW-1:0] mq[$];       // bytes held by the buffer
  logic [DW-1:0] exp_q[$];    // bytes expected at the output, in order
  bit            m_init  = 1'b0;
  bit            m_send  = 1'b0;
  bit            m_done  = 1'b0;
  bit            m_ovf   = 1'b0;
  bit            m_valid = 1'b0;
  bit            m_full  = 1'b0;
  int            m_cnt   = 0;
  logic [DW-1:0] m_dout  = '0;

  int next_byte;
  int wr_left;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock edge of the frame feeder, described from its rules.
  task automatic model(input bit r, input bit s, input bit w, input logic [DW-1:0] d, input bit b);
    bit was_full;
    bit pop;
    m_init = 1'b1;
    if (r) begin
      mq.delete();
      exp_q.delete();
      m_send  = 1'b0;
      m_done  = 1'b0;
      m_cnt   = 0;
      m_ovf   = 1'b0;
      m_valid = 1'b0;
      m_dout  = '0;
    end else begin
      was_full = (mq.size() == DEPTH);
      pop      = m_send && !b && (mq.size() > 0) && (m_cnt < FL);
      m_valid  = pop;
      if (pop) begin
        m_dout = mq.pop_front();
        exp_q.push_back(m_dout);
        m_cnt++;
      end
      if (w) begin
        if (!was_full || pop) mq.push_back(d);
        else                  m_ovf = 1'b1;
      end
      if (m_send) begin
        if (m_cnt == FL) begin
          m_send = 1'b0;
          m_done = 1'b1;
        end
      end else if (s) begin
        m_send = 1'b1;
        m_done = 1'b0;
        m_cnt  = 0;
      end
    end
    m_full = (mq.size() == DEPTH);
  endtask

  task automatic cyc(input bit r, input bit s, input bit w, input logic [DW-1:0] d, input bit b);
    rst     = r;
    start   = s;
    wr_en   = w;
    wr_data = d;
    busy    = b;
    @(posedge clk);
    model(r, s, w, d, b);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"},    data_valid, 1'b0);
    chk({tag, "_dout"},     data_out,   '0);
    chk({tag, "_done"},     done,       1'b0);
    chk({tag, "_overflow"}, overflow,   1'b0);
    chk({tag, "_full"},     full,       1'b0);
  endtask

  // Run the current frame with writes paced by the buffer level until the
  // model has sent stop_cnt bytes or the frame ends; optionally pulse start
  // once when byte start_at has gone out.
  task automatic stream(input int stop_cnt, input int start_at, input int maxcyc);
    bit fired;
    int n;
    bit w;
    bit s;
    fired = 1'b0;
    n     = 0;
    while (m_send && (m_cnt < stop_cnt) && (n < maxcyc)) begin
      w = (wr_left > 0) && !m_full;
      s = !fired && (m_cnt == start_at);
      if (s) fired = 1'b1;
      cyc(1'b0, s, w, next_byte[DW-1:0], 1'b0);
      if (w) begin
        next_byte++;
        wr_left--;
      end
      n++;
    end
    chk("stream_in_budget", (n < maxcyc), 1'b1);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (m_init) begin
      chk("data_valid", data_valid, m_valid);
      if (data_valid === 1'b1) begin
        n_obs++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_byte: got 0x%0h expected no byte at %0t", data_out, $time);
        end else begin
          chk("data_out", data_out, exp_q.pop_front());
        end
      end else begin
        chk("data_out_hold", data_out, m_dout);
      end
      chk("done",     done,     m_done);
      chk("full",     full,     m_full);
      chk("overflow", overflow, m_ovf);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int obs0;
    logic [DW-1:0] rb;
    bit r, s, w, b;

    rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_data = '0; busy = 1'b0;
    repeat (3) cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk_reset("por");

    // Full ordered frame 0x00..0xFF
    next_byte = 0;
    wr_left   = 256;
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 1'b0, 1'b1, next_byte[DW-1:0], 1'b0);
      next_byte++;
      wr_left--;
    end
    chk("t1_full_before_start", full, 1'b1);
    obs0 = n_obs;
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    stream(FL, -1, 3000);
    @(negedge clk); #1;
    chk("t1_pulses",   n_obs - obs0, 32'd256);
    chk("t1_done",     done,         1'b1);
    chk("t1_overflow", overflow,     1'b0);

    // Single byte latency into an empty buffer while sending
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("t2_done_cleared", done, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);
    chk("t2_no_bypass", data_valid, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("t2_valid", data_valid, 1'b1);
    chk("t2_data",  data_out,   8'hA5);

    // Backpressure window on cycles 10..14
    for (int c = 0; c < 30; c++) begin
      rb = DW'($urandom);
      b  = (c >= 10) && (c <= 14);
      cyc(1'b0, 1'b0, 1'b1, rb, b);
      if (b) chk("t3_stall", data_valid, 1'b0);
    end
    repeat (12) cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);

    // Overflow at full, then a write at full with a simultaneous pop
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b0, 1'b1, DW'(i), 1'b1);
    chk("t4_full",        full,     1'b1);
    chk("t4_no_overflow", overflow, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 8'h77, 1'b1);
    chk("t4_overflow",    overflow, 1'b1);
    chk("t4_still_full",  full,     1'b1);
    cyc(1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
    chk("t4_full_after_swap", full,       1'b1);
    chk("t4_swap_valid",      data_valid, 1'b1);
    chk("t4_swap_data",       data_out,   8'h00);
    repeat (20) cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);

    // Reset mid-frame after 100 bytes, then a fresh frame with an ignored start
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    next_byte = int'($urandom_range(0, 255));
    wr_left   = 1000;
    stream(100, -1, 1000);
    chk("t5_at_100", m_cnt, 32'd100);
    cyc(1'b1, 1'b1, 1'b1, 8'h5A, 1'b0);
    chk_reset("t5_rst");
    obs0 = n_obs;
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    next_byte = 8'hC0;
    wr_left   = 256;
    stream(FL, 50, 3000);
    @(negedge clk); #1;
    chk("t6_pulses", n_obs - obs0, 32'd256);
    chk("t6_done",   done,         1'b1);

    // Randomized traffic
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 499) == 0);
      s  = ($urandom_range(0, 39) == 0);
      w  = ($urandom_range(0, 3) != 0);
      b  = ($urandom_range(0, 3) == 0);
      rb = DW'($urandom);
      cyc(r, s, w, rb, b);
    end
    repeat (4) cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mask_feeder.md
MASK_FEEDER -- requirements
Module: mask_feeder

Interface
REQ-001 Parameter DATA_W, default 8: byte width of the stream.
REQ-002 Parameter DEPTH, default 16: FIFO entries, power of two.
REQ-003 Parameter FRAME_LEN, default 256: bytes sent per frame.
REQ-004 clk  input  1: single clock; all logic on rising edge.
REQ-005 rst  input  1: reset, synchronous, active-high.
REQ-006 start  input  1: one-cycle pulse that begins a frame.
REQ-007 wr_en  input  1: upstream write strobe.
REQ-008 wr_data  input  DATA_W: upstream byte.
REQ-009 full  output  1: FIFO holds DEPTH bytes.
REQ-010 overflow  output  1: sticky flag, set when a write is dropped.
REQ-011 busy  input  1: downstream backpressure; when high, the block sends no byte.
REQ-012 data_out  output  DATA_W: byte to downstream, registered.
REQ-013 data_valid  output  1: data_out carries a new byte this cycle.
REQ-014 done  output  1: frame complete; held high until the next start or rst.

Function
REQ-015 States: IDLE, SEND, DONE.
- IDLE->SEND on start.
- SEND->DONE when the byte counter reaches FRAME_LEN.
- DONE->SEND on start, which also clears the counter.
REQ-016 start while in SEND is ignored.
REQ-017 A write is accepted when wr_en=1 and (!full or a pop occurs in the same cycle); the pop frees the slot, so the write is kept.
REQ-018 A write with wr_en=1, full=1 and no pop is dropped, and overflow is set at the next edge.
REQ-019 Writes are accepted in every state, including IDLE and DONE.
REQ-020 Pop condition: state==SEND, busy==0 (sampled at the edge), FIFO not empty at that edge, and count<FRAME_LEN.
REQ-021 No bypass: a byte written at edge n can pop no earlier than edge n+1.
REQ-022 On pop: data_out is loaded with the FIFO head, data_valid=1 for the following cycle, and the counter increments.
REQ-023 With no pop, data_valid=0 and data_out holds its last value; the output is never driven to Z.
REQ-024 Latency: with busy low and the FIFO empty, a byte written at edge n appears with data_valid=1 after edge n+1.
REQ-025 Busy while in SEND stalls the stream without losing bytes; sending resumes on the first edge at which busy is sampled low.
REQ-026 The counter is DATA_W+1 bits wide so it can hold FRAME_LEN=256 without wrap.
REQ-027 The FIFO read and write pointers wrap modulo DEPTH.
REQ-028 full and empty are derived from an occupancy count of 0..DEPTH.
REQ-029 done asserts on the edge that enters DONE, which is the same edge as the final pop.
REQ-030 Bytes left in the FIFO after DONE are retained and go out first in the next frame.

Reset
REQ-031 rst=1 at an edge: state=IDLE, FIFO emptied, counter=0, data_out=0, data_valid=0, done=0, overflow=0, full=0.
REQ-032 rst takes priority over start, wr_en and pop in the same cycle.
REQ-033 rst during SEND aborts the frame; no byte is emitted in the cycle after reset.

Structure
REQ-034 Package mask_pkg holds the state enum (IDLE, SEND, DONE), DATA_W and the default DEPTH and FRAME_LEN constants.
REQ-035 The FIFO is a sub-module named sync_fifo: parameters DATA_W and DEPTH; ports clk, rst, push, pop, din, dout, full, empty.
REQ-036 The FSM, counter and output registers stay in mask_feeder.

Verification
REQ-037 Write 0x00..0xFF (256 bytes, paced by full), start, busy=0: exactly 256 data_valid pulses in order 0x00..0xFF, then done=1, overflow=0.
REQ-038 Write 0xA5 into an empty FIFO at edge n while in SEND: data_out=0xA5 and data_valid=1 after edge n+1.
REQ-039 Stream with busy=1 for cycles 10-14: no data_valid in the cycles after those edges; the sequence resumes with no byte lost or duplicated.
REQ-040 Fill 16 bytes with busy=1, then write 0x77: full=1, overflow=1, 0x77 absent from the output. Repeat at full with a pop in the same cycle: 0x77 accepted.
REQ-041 Assert rst mid-frame after 100 bytes: all outputs at reset values next cycle. After start, output begins with newly written data and the count restarts at 0.
REQ-042 start while in SEND at byte 50: ignored; done after exactly 256 bytes.
